// File: rtl/nf_identifier_pkg.sv
// Shared constants, response codes and FSM states for the
// board identifier AXI4-Lite peripheral.
package nf_identifier_pkg;

   localparam logic [11:0] OFF_VERSION = 12'h000;
   localparam logic [11:0] OFF_SCRATCH = 12'h004;
   localparam logic [11:0] OFF_UP_SEC  = 12'h008;
   localparam logic [11:0] OFF_UP_TICK = 12'h00C;
   localparam logic [11:0] OFF_CYC_LO  = 12'h010;
   localparam logic [11:0] OFF_CYC_HI  = 12'h014;
   localparam logic [11:0] OFF_ID_BASE = 12'h020;

   localparam logic [15:0] VERSION_MAJOR = 16'h0002;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      RD_IDLE,
      RD_RESP
   } rd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_HAVE_AW,
      WR_HAVE_W,
      WR_RESP
   } wr_state_e;

   function automatic logic [31:0] apply_wstrb(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  strb
   );
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/nf_identifier_v2_if.sv
// AXI4-Lite bundle for the identifier peripheral.
// master drives AW/W/AR and B/R ready; slave answers.
interface nf_identifier_v2_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   S_AXI_AWADDR;
   logic            S_AXI_AWVALID;
   logic            S_AXI_AWREADY;
   logic [DW-1:0]   S_AXI_WDATA;
   logic [DW/8-1:0] S_AXI_WSTRB;
   logic            S_AXI_WVALID;
   logic            S_AXI_WREADY;
   logic [1:0]      S_AXI_BRESP;
   logic            S_AXI_BVALID;
   logic            S_AXI_BREADY;
   logic [AW-1:0]   S_AXI_ARADDR;
   logic            S_AXI_ARVALID;
   logic            S_AXI_ARREADY;
   logic [DW-1:0]   S_AXI_RDATA;
   logic [1:0]      S_AXI_RRESP;
   logic            S_AXI_RVALID;
   logic            S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY,
      input  S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY,
      input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY,
      output S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY,
      output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

endinterface

// File: rtl/nf_identifier_uptime.sv
// Uptime counters: tick (0..C_FREQ_HZ-1), seconds, 64-bit cycles.
// Ports: clk_i, rst_ni in; tick_o, sec_o, cycle_o out.
module nf_identifier_uptime #(
   parameter int C_FREQ_HZ = 100000000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [31:0] tick_o,
   output logic [31:0] sec_o,
   output logic [63:0] cycle_o
);

   localparam logic [31:0] TICK_MAX = 32'(C_FREQ_HZ - 1);

   logic [31:0] tick_q;
   logic [31:0] sec_q;
   logic [63:0] cycle_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_q  <= '0;
         sec_q   <= '0;
         cycle_q <= '0;
      end else begin
         cycle_q <= cycle_q + 64'd1;
         if (tick_q == TICK_MAX) begin
            tick_q <= '0;
            sec_q  <= sec_q + 32'd1;
         end else begin
            tick_q <= tick_q + 32'd1;
         end
      end
   end

   assign tick_o  = tick_q;
   assign sec_o   = sec_q;
   assign cycle_o = cycle_q;

endmodule

// File: rtl/nf_identifier_v2.sv
// AXI4-Lite identifier: version, scratch, uptime, cycle, ID words.
// Ports: S_AXI_ACLK, S_AXI_ARESETN, s_axi (slave AXI4-Lite bundle).
module nf_identifier_v2
   import nf_identifier_pkg::*;
#(
   parameter int           C_S_AXI_DATA_WIDTH   = 32,
   parameter int           C_S_AXI_ADDR_WIDTH   = 32,
   parameter logic [31:0]  C_BASEADDR           = 32'hFFFFFFFF,
   parameter logic [31:0]  C_HIGHADDR           = 32'h00000000,
   parameter int           C_S_AXI_ACLK_FREQ_HZ = 100000000,
   parameter int           C_NUM_ID_WORDS       = 3,
   parameter logic [255:0] C_ID_WORDS           = 256'h0
) (
   input logic               S_AXI_ACLK,
   input logic               S_AXI_ARESETN,
   nf_identifier_v2_if.slave s_axi
);

   localparam logic [31:0] VERSION =
      {VERSION_MAJOR, 8'(C_NUM_ID_WORDS), 8'h00};

   logic [31:0] tick;
   logic [31:0] sec;
   logic [63:0] cycle;

   nf_identifier_uptime #(
      .C_FREQ_HZ (C_S_AXI_ACLK_FREQ_HZ)
   ) u_uptime (
      .clk_i   (S_AXI_ACLK),
      .rst_ni  (S_AXI_ARESETN),
      .tick_o  (tick),
      .sec_o   (sec),
      .cycle_o (cycle)
   );

   // Window placement is the interconnect's job; only ADDR[11:0] decodes.
   logic unused_bits;
   assign unused_bits = ^{s_axi.S_AXI_ARADDR, s_axi.S_AXI_AWADDR,
                          C_BASEADDR, C_HIGHADDR,
                          32'(C_S_AXI_DATA_WIDTH),
                          32'(C_S_AXI_ADDR_WIDTH)};

   logic [31:0] id_w [8];
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         id_w[i] = C_ID_WORDS[i*32 +: 32];
      end
   end

   rd_state_e   rd_state_q;
   logic        arready_q;
   logic        rvalid_q;
   logic [31:0] rdata_q;
   logic [1:0]  rresp_q;
   logic [63:0] shadow_q;
   logic [31:0] scratch_q;

   logic [11:0] ar_off;
   logic        ar_fire;
   logic        is_id;
   logic [31:0] rd_data_d;
   logic [1:0]  rd_resp_d;
   logic        cap_d;

   assign ar_off  = s_axi.S_AXI_ARADDR[11:0];
   assign ar_fire = s_axi.S_AXI_ARVALID & arready_q;
   assign is_id   = (ar_off[11:5] == OFF_ID_BASE[11:5]) &&
                    ({29'd0, ar_off[4:2]} < 32'(C_NUM_ID_WORDS));

   always_comb begin
      rd_data_d = '0;
      rd_resp_d = RESP_SLVERR;
      cap_d     = 1'b0;
      if (ar_off[1:0] == 2'b00) begin
         rd_resp_d = RESP_OKAY;
         case (ar_off)
            OFF_VERSION: rd_data_d = VERSION;
            OFF_SCRATCH: rd_data_d = scratch_q;
            OFF_UP_SEC:  rd_data_d = sec;
            OFF_UP_TICK: rd_data_d = tick;
            OFF_CYC_LO: begin
               rd_data_d = cycle[31:0];
               cap_d     = 1'b1;
            end
            OFF_CYC_HI:  rd_data_d = shadow_q[63:32];
            default: begin
               if (is_id) rd_data_d = id_w[ar_off[4:2]];
               else       rd_resp_d = RESP_SLVERR;
            end
         endcase
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_state_q <= RD_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
         shadow_q   <= '0;
      end else begin
         case (rd_state_q)
            RD_IDLE: begin
               arready_q <= 1'b1;
               if (ar_fire) begin
                  arready_q  <= 1'b0;
                  rvalid_q   <= 1'b1;
                  rdata_q    <= rd_data_d;
                  rresp_q    <= rd_resp_d;
                  rd_state_q <= RD_RESP;
                  if (cap_d) shadow_q <= cycle;
               end
            end
            RD_RESP: begin
               if (s_axi.S_AXI_RREADY) begin
                  rvalid_q   <= 1'b0;
                  arready_q  <= 1'b1;
                  rd_state_q <= RD_IDLE;
               end
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   wr_state_e   wr_state_q;
   logic        awready_q;
   logic        wready_q;
   logic        bvalid_q;
   logic [1:0]  bresp_q;
   logic [11:0] awaddr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;

   logic        aw_fire;
   logic        w_fire;
   logic [11:0] wr_off;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_ok;
   logic        commit;
   logic [31:0] scratch_d;

   assign aw_fire = s_axi.S_AXI_AWVALID & awready_q;
   assign w_fire  = s_axi.S_AXI_WVALID & wready_q;

   // Pick the captured half or the live bus, whichever arrived first.
   always_comb begin
      wr_off  = s_axi.S_AXI_AWADDR[11:0];
      wr_data = s_axi.S_AXI_WDATA;
      wr_strb = s_axi.S_AXI_WSTRB;
      if (wr_state_q == WR_HAVE_AW) wr_off = awaddr_q;
      if (wr_state_q == WR_HAVE_W) begin
         wr_data = wdata_q;
         wr_strb = wstrb_q;
      end
      wr_ok     = (wr_off == OFF_SCRATCH);
      scratch_d = apply_wstrb(scratch_q, wr_data, wr_strb);
      commit    = 1'b0;
      unique case (1'b1)
         (wr_state_q == WR_IDLE):    commit = aw_fire & w_fire;
         (wr_state_q == WR_HAVE_AW): commit = w_fire;
         (wr_state_q == WR_HAVE_W):  commit = aw_fire;
         default:                    commit = 1'b0;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_state_q <= WR_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         scratch_q  <= '0;
      end else begin
         case (wr_state_q)
            WR_IDLE: begin
               awready_q <= ~aw_fire;
               wready_q  <= ~w_fire;
               if (aw_fire) awaddr_q <= s_axi.S_AXI_AWADDR[11:0];
               if (w_fire) begin
                  wdata_q <= s_axi.S_AXI_WDATA;
                  wstrb_q <= s_axi.S_AXI_WSTRB;
               end
               if (aw_fire)     wr_state_q <= WR_HAVE_AW;
               else if (w_fire) wr_state_q <= WR_HAVE_W;
            end
            WR_HAVE_AW: ;
            WR_HAVE_W:  ;
            WR_RESP: begin
               if (s_axi.S_AXI_BREADY) begin
                  bvalid_q   <= 1'b0;
                  awready_q  <= 1'b1;
                  wready_q   <= 1'b1;
                  wr_state_q <= WR_IDLE;
               end
            end
            default: wr_state_q <= WR_IDLE;
         endcase
         if (commit) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            wr_state_q <= WR_RESP;
            if (wr_ok) scratch_q <= scratch_d;
         end
      end
   end

   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;

endmodule

// File: tb/tb_nf_identifier_v2.sv
// Bench for nf_identifier_v2: random AXI traffic vs a
// time-based reference model of the register map.
module tb_nf_identifier_v2;

   localparam int FREQ = 10;
   localparam int NID  = 3;
   localparam logic [255:0] IDW =
      {160'h0, 32'hCAFE_0002, 32'hBEEF_0001, 32'h1234_0000};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;
   time  t0 = 0;

   logic [31:0] scratch_m = '0;
   logic [63:0] shadow_m  = '0;

   nf_identifier_v2_if #(.AW(32), .DW(32)) bus ();

   nf_identifier_v2 #(
      .C_S_AXI_ACLK_FREQ_HZ (FREQ),
      .C_NUM_ID_WORDS       (NID),
      .C_ID_WORDS           (IDW)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .s_axi         (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: counters are a pure function of edges since reset.
   task automatic model_read(input logic [31:0] addr, input time t,
                             output logic [31:0] d,
                             output logic [1:0] r);
      logic [11:0] off;
      longint unsigned cyc;
      int idx;
      off = addr[11:0];
      cyc = longint'((t - t0) / 10);
      d = '0;
      r = 2'b10;
      if (off[1:0] == 2'b00) begin
         r = 2'b00;
         if (off == 12'h000) d = {16'h0002, 8'(NID), 8'h00};
         else if (off == 12'h004) d = scratch_m;
         else if (off == 12'h008) d = 32'(cyc / FREQ);
         else if (off == 12'h00C) d = 32'(cyc % FREQ);
         else if (off == 12'h010) begin
            d = cyc[31:0];
            shadow_m = cyc;
         end
         else if (off == 12'h014) d = shadow_m[63:32];
         else if (off >= 12'h020 && int'(off) < 32 + 4 * NID) begin
            idx = (int'(off) - 32) / 4;
            d = IDW[idx*32 +: 32];
         end
         else r = 2'b10;
      end
   endtask

   task automatic axi_read(input logic [31:0] addr,
                           output logic [31:0] d,
                           output logic [1:0] r,
                           output time t);
      int n;
      @(negedge clk);
      bus.S_AXI_ARADDR  = addr;
      bus.S_AXI_ARVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_ARREADY && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("arready_wait", bus.S_AXI_ARREADY, 1);
      @(posedge clk);
      t = $time;
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      chk("rvalid_k1", bus.S_AXI_RVALID, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      d = bus.S_AXI_RDATA;
      r = bus.S_AXI_RRESP;
      bus.S_AXI_RREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      chk("ar_return", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b01);
   endtask

   task automatic do_read(input logic [31:0] addr);
      logic [31:0] d, ed;
      logic [1:0] r, er;
      time t;
      axi_read(addr, d, r, t);
      model_read(addr, t, ed, er);
      chk($sformatf("rdata_%03h", addr[11:0]), d, ed);
      chk($sformatf("rresp_%03h", addr[11:0]), r, er);
   endtask

   task automatic axi_write(input logic [31:0] addr,
                            input logic [31:0] data,
                            input logic [3:0] strb,
                            input int awd, input int wd, input int bd,
                            output logic [1:0] r);
      int c;
      bit aw_done, w_done, aw_hs, w_hs;
      c = 0;
      aw_done = 0;
      w_done = 0;
      bus.S_AXI_AWADDR = addr;
      bus.S_AXI_WDATA  = data;
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_BREADY = 1'b0;
      while (!(aw_done && w_done) && c < 50) begin
         @(negedge clk);
         bus.S_AXI_AWVALID = !aw_done && c >= awd;
         bus.S_AXI_WVALID  = !w_done && c >= wd;
         aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
         w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
         @(posedge clk);
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done = 1;
         c++;
      end
      @(negedge clk);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      chk("aw_w_done", {aw_done, w_done}, 2'b11);
      chk("bvalid_k1", bus.S_AXI_BVALID, 1);
      repeat (bd) @(negedge clk);
      chk("bvalid_hold", bus.S_AXI_BVALID, 1);
      r = bus.S_AXI_BRESP;
      bus.S_AXI_BREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.S_AXI_BREADY = 1'b0;
      chk("b_single",
          {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY},
          3'b011);
   endtask

   task automatic do_write(input logic [31:0] addr,
                           input logic [31:0] data,
                           input logic [3:0] strb,
                           input int awd, input int wd, input int bd);
      logic [1:0] r, er;
      axi_write(addr, data, strb, awd, wd, bd, r);
      er = 2'b10;
      if (addr[11:0] == 12'h004) begin
         er = 2'b00;
         for (int b = 0; b < 4; b++)
            if (strb[b]) scratch_m[8*b +: 8] = data[8*b +: 8];
      end
      chk($sformatf("bresp_%03h", addr[11:0]), r, er);
   endtask

   logic [31:0] rd_addrs [15] = '{
      32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h014,
      32'h018, 32'h01C, 32'h020, 32'h024, 32'h028, 32'h02C,
      32'h105, 32'h1004, 32'h012
   };
   logic [31:0] wr_addrs [7] = '{
      32'h004, 32'h004, 32'h000, 32'h008, 32'h020,
      32'h006, 32'h1004
   };

   initial begin
      logic [31:0] lo, hi, nv;
      logic [1:0] r1, r2;
      logic [63:0] prev, cur;
      bit have_prev;
      time tt;

      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '0;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_BREADY  = 1'b0;
      bus.S_AXI_ARADDR  = '0;
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_RREADY  = 1'b0;

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready",
          {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 0);
      chk("rst_valid", {bus.S_AXI_RVALID, bus.S_AXI_BVALID}, 0);
      chk("rst_resp",
          {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP}, 0);
      rst_n = 1'b1;
      t0 = $time + 5;
      @(negedge clk);
      chk("post_rst_ready",
          {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY},
          3'b111);

      // Uptime after ~25 cycles, then HI before any LO read.
      repeat (23) @(negedge clk);
      do_read(32'h008);
      do_read(32'h00C);
      do_read(32'h014);

      do_read(32'h000);
      do_read(32'h028);

      do_write(32'h004, 32'hDEADBEEF, 4'b0101, 0, 0, 0);
      chk("strb_model", scratch_m, 32'h00AD00EF);
      do_read(32'h004);

      do_write(32'h004, 32'h12345678, 4'b1111, 3, 0, 5);
      do_read(32'h004);
      do_write(32'h004, 32'hA5A5A5A5, 4'b1000, 0, 2, 1);
      do_read(32'h004);

      do_read(32'h018);
      do_write(32'h008, 32'hFFFFFFFF, 4'b1111, 1, 1, 0);
      do_read(32'h008);
      do_read(32'h004);

      do_read(32'h010);
      repeat (4) @(negedge clk);
      do_read(32'h014);

      // Read and write of SCRATCH accepted on the same edge.
      nv = 32'h0BAD_F00D;
      @(negedge clk);
      bus.S_AXI_ARADDR  = 32'h004;
      bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_AWADDR  = 32'h004;
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WDATA   = nv;
      bus.S_AXI_WSTRB   = 4'hF;
      bus.S_AXI_WVALID  = 1'b1;
      chk("same_ready",
          {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY},
          3'b111);
      @(posedge clk);
      @(negedge clk);
      bus.S_AXI_ARVALID = 1'b0;
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      chk("same_rd_old", bus.S_AXI_RDATA, scratch_m);
      chk("same_resp",
          {bus.S_AXI_RVALID, bus.S_AXI_RRESP,
           bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 6'b100100);
      bus.S_AXI_RREADY = 1'b1;
      bus.S_AXI_BREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.S_AXI_RREADY = 1'b0;
      bus.S_AXI_BREADY = 1'b0;
      scratch_m = nv;
      do_read(32'h004);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            do_write(wr_addrs[$urandom_range(0, 6)], $urandom,
                     4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3));
         end else begin
            do_read(rd_addrs[$urandom_range(0, 14)]);
         end
      end

      // Push the cycle counter just below a 32-bit rollover.
      @(negedge clk);
      force dut.u_uptime.cycle_q = 64'h0000_0000_FFFF_FFE8;
      @(negedge clk);
      release dut.u_uptime.cycle_q;
      have_prev = 0;
      prev = '0;
      for (int i = 0; i < 6; i++) begin
         axi_read(32'h010, lo, r1, tt);
         axi_read(32'h014, hi, r2, tt);
         cur = {hi, lo};
         chk("cyc_resp", {r1, r2}, 4'b0000);
         if (have_prev) begin
            chk("cyc_mono", cur > prev, 1);
            chk("cyc_step", (cur - prev) < 64'd64, 1);
         end
         prev = cur;
         have_prev = 1;
         repeat (2) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule

// File: doc/nf_identifier_v2.md
# nf_identifier_v2

Parametrised AXI4-Lite identification block, next generation of the board identifier peripheral. Holds C_NUM_ID_WORDS build-time identity words (date, time, project ID, git hash, ...), a version word, a writable scratch register, uptime counters and a 64-bit cycle counter with coherent read. It implements the AXI4-Lite slave directly, without the IPIF shim, and sits on the host register interconnect next to the other control peripherals.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 32, address width
- C_BASEADDR, 32'hFFFFFFFF, window base; the decode uses offset = ADDR[11:0]
- C_HIGHADDR, 32'h00000000, window top; used by the interconnect only
- C_S_AXI_ACLK_FREQ_HZ, 100000000, ticks per second for the uptime counter; must be ≥ 2
- C_NUM_ID_WORDS, 3, number of identity words, 1..8
- C_ID_WORDS, 256'h0, packed identity words; word i = bits [32i+31:32i]
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESETN  in  1  asynchronous, active-low reset
- S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: standard AXI4-Lite write channels; widths follow the parameters
- S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite read channels

## Operation
- Register map:
  - 0x00 VERSION, RO: {16'h0002, 8'(C_NUM_ID_WORDS), 8'h00}
  - 0x04 SCRATCH, RW: reset 0; writes honour WSTRB per byte
  - 0x08 UPTIME_SEC, RO
  - 0x0C UPTIME_TICK, RO
  - 0x10 CYCLE_LO, RO
  - 0x14 CYCLE_HI, RO
  - 0x20+4i ID word i, RO, for i < C_NUM_ID_WORDS
- Error responses:
  - Any other offset, or an offset with ADDR[1:0] ≠ 0: RRESP/BRESP = SLVERR (2'b10), RDATA = 0.
  - A write to an RO register: BRESP = SLVERR, no state change.
  - All other accesses return OKAY.
- Counters:
  - Tick counter runs 0..C_S_AXI_ACLK_FREQ_HZ−1. On the wrap cycle, UPTIME_SEC increments. UPTIME_SEC is 32-bit and wraps to 0.
  - Cycle counter is 64-bit, free-running, and increments every cycle after reset.
- Coherent cycle read:
  - The accepted read of CYCLE_LO captures the full 64-bit value into a shadow register and returns shadow[31:0].
  - A read of CYCLE_HI returns shadow[63:32]. If CYCLE_LO was never read, this is 0.
- Read FSM (states RD_IDLE, RD_RESP):
  - In RD_IDLE, ARREADY = 1. On ARVALID&ARREADY, RDATA and RRESP are registered and the FSM moves to RD_RESP.
  - In RD_RESP, RVALID = 1 and RDATA/RRESP are held until RREADY, then the FSM returns to RD_IDLE.
- Write FSM (states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP):
  - AW and W are accepted independently. AWREADY stays high until the AW handshake; WREADY stays high until the W handshake.
  - Once both are captured, the write is performed and the FSM moves to WR_RESP, holding BVALID until BREADY.
- Simultaneous read and write: the channels are independent. A read of SCRATCH accepted in the same cycle as the write commit returns the old value.

## Timing
- Reset values: ARREADY, AWREADY, WREADY, RVALID and BVALID are 0 while ARESETN is low. RDATA = 0 and RRESP = BRESP = 0. All counters, SCRATCH and the shadow register are 0.
- First cycle after reset release: ARREADY, AWREADY and WREADY go to 1.
- Read: AR handshake at edge k → RVALID = 1 from cycle k+1. If RREADY is high at k+1, ARREADY returns at k+2. Minimum is one read per 2 cycles.
- Write: when the later of the AW/W handshakes occurs at edge k, SCRATCH updates at k and BVALID = 1 from cycle k+1. AWREADY and WREADY return the cycle after the B handshake.
- Counters are not stalled by bus activity.
- Any value read reflects the counter state at the AR handshake edge.
- Reset asserted mid-transaction aborts it immediately. No response is issued.

## Structure
- Package nf_identifier_pkg holds:
  - register offset constants
  - VERSION_MAJOR = 16'h0002
  - RESP_OKAY/RESP_SLVERR
  - the read and write state enums
- Sub-module nf_identifier_uptime holds the tick, seconds and 64-bit cycle counters. Its outputs are tick, sec and cycle.
- The AXI FSMs, decode, scratch and shadow live in the top level.

## Test plan
- Reset, then read 0x00 with C_NUM_ID_WORDS=3 → RDATA 32'h0002_0300, RRESP 0. Read 0x28 → ID word 2.
- Write 0x04 with data 32'hDEADBEEF, WSTRB 4'b0101, then read 0x04 → 32'h00AD00EF.
- Present W three cycles before AW, and hold BREADY low for 5 cycles → single BVALID, held until BREADY; SCRATCH updated once.
- Read 0x18, and write 0x08 → both SLVERR; no state change; RDATA 0.
- With C_S_AXI_ACLK_FREQ_HZ=10, wait 25 cycles from reset, read 0x08/0x0C → tick and seconds consistent with a 10-cycle second (±read latency). Read CYCLE_LO then CYCLE_HI across a forced 32-bit rollover → HI:LO is monotonic and coherent.
- Drive AR and AW/W to SCRATCH in the same cycle → read returns the old value, and a follow-up read returns the new value.
